// File: rtl/tetris_pkg.sv
// Shared types and constants for the falling-piece controller.
package tetris_pkg;

  // Board dimensions in cells. The collision checker owns the board edges;
  // these are the shared defaults for the blocks that sit around it.
  localparam int BOARD_W = 10;
  localparam int BOARD_H = 20;

  // Shape codes understood by single_shape.
  typedef enum logic [2:0] {
    LINE   = 3'd0,
    SQUARE = 3'd1,
    T      = 3'd2,
    L      = 3'd3,
    J      = 3'd4,
    Z      = 3'd5,
    S      = 3'd6
  } shape_t;

  // Orientation codes. A rotate steps clockwise and wraps after LEFT.
  localparam logic [1:0] UP    = 2'b00;
  localparam logic [1:0] RIGHT = 2'b01;
  localparam logic [1:0] DOWN  = 2'b10;
  localparam logic [1:0] LEFT  = 2'b11;

  // Controller FSM states, also exported on the debug port.
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_SPAWN      = 3'd1,
    ST_WAIT       = 3'd2,
    ST_CHECK_REQ  = 3'd3,
    ST_CHECK_RESP = 3'd4,
    ST_LOCK       = 3'd5,
    ST_OVER       = 3'd6
  } ctrl_state_t;

  // What the candidate in flight was built from; decides how a collision
  // is handled and which pending flag is retired.
  typedef enum logic [2:0] {
    REQ_ROT   = 3'd0,
    REQ_LEFT  = 3'd1,
    REQ_RIGHT = 3'd2,
    REQ_GRAV  = 3'd3,
    REQ_SPAWN = 3'd4
  } req_kind_t;

endpackage

// File: rtl/gravity_timer.sv
// Free-running gravity period counter. tick pulses for one cycle each time
// the count wraps from DROP_CYCLES-1 back to 0. clr wins over en.
module gravity_timer #(
  parameter int DROP_CYCLES = 50_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DROP_CYCLES > 1) ? $clog2(DROP_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DROP_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count and wrap pulse.
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/piece_ctrl.sv
// Active-piece sequencer: spawn, move/rotate/gravity requests, collision
// checks through an external checker, lock and game over.
// Optional build macro HARD_DROP_EN adds the hard_drop input and the
// back-to-back gravity loop that drops the piece straight to its rest row.
//
// Checker handshake: cand_valid is high for exactly one cycle (SPAWN or
// CHECK_REQ) while cand_x/cand_y/cand_orient hold the candidate; the checker
// answers on collide in the following cycle (CHECK_RESP), where it is
// sampled once. There is no backpressure; the checker must answer in time.
module piece_ctrl
  import tetris_pkg::*;
#(
  parameter int DROP_CYCLES = 50_000_000,
  parameter int SPAWN_X     = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  next_shape,
  input  logic        mv_left,
  input  logic        mv_right,
  input  logic        rotate,
`ifdef HARD_DROP_EN
  input  logic        hard_drop,
`endif
  output logic [4:0]  cand_x,
  output logic [4:0]  cand_y,
  output logic [1:0]  cand_orient,
  output logic        cand_valid,
  input  logic        collide,
  output logic [2:0]  shape_req,
  output logic [1:0]  orient,
  output logic [4:0]  pos_x,
  output logic [4:0]  pos_y,
  output logic        lock_pulse,
  output logic        game_over,
  output ctrl_state_t dbg_state
);

  localparam logic [4:0] SPAWN_X_C = 5'(SPAWN_X);

  ctrl_state_t state_q, state_d;
  shape_t      shape_q, shape_d;
  req_kind_t   kind_q, kind_d;
  logic [1:0]  orient_q, orient_d, cand_orient_q, cand_orient_d;
  logic [4:0]  pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic [4:0]  cand_x_q, cand_x_d, cand_y_q, cand_y_d;
  logic        game_over_q, game_over_d;
  logic        rot_pend_q, rot_pend_d, left_pend_q, left_pend_d;
  logic        right_pend_q, right_pend_d, grav_pend_q, grav_pend_d;
  logic        clr_rot, clr_left, clr_right, clr_grav, clr_all;
  logic        req_en, grav_tick;
`ifdef HARD_DROP_EN
  logic        hd_pend_q, hd_pend_d, hd_active_q, hd_active_d, clr_hd;
`endif

  // Requests are only accepted while a game is running.
  assign req_en = (state_q != ST_IDLE) && (state_q != ST_OVER);

  gravity_timer #(
    .DROP_CYCLES(DROP_CYCLES)
  ) u_gravity_timer (
    .clk  (clk),
    .reset(reset),
    .en   (req_en),
    .clr  (state_q == ST_SPAWN),
    .tick (grav_tick)
  );

  // FSM next state, candidate formation and active-piece update.
  always_comb begin
    state_d       = state_q;
    shape_d       = shape_q;
    kind_d        = kind_q;
    orient_d      = orient_q;
    pos_x_d       = pos_x_q;
    pos_y_d       = pos_y_q;
    cand_x_d      = cand_x_q;
    cand_y_d      = cand_y_q;
    cand_orient_d = cand_orient_q;
    game_over_d   = game_over_q;
    clr_rot       = 1'b0;
    clr_left      = 1'b0;
    clr_right     = 1'b0;
    clr_grav      = 1'b0;
    clr_all       = 1'b0;
`ifdef HARD_DROP_EN
    clr_hd        = 1'b0;
    hd_active_d   = hd_active_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_SPAWN;
      end
      ST_SPAWN: begin
        shape_d  = shape_t'(next_shape);
        orient_d = UP;
        pos_x_d  = SPAWN_X_C;
        pos_y_d  = 5'd0;
        kind_d   = REQ_SPAWN;
        state_d  = ST_CHECK_RESP;
      end
      ST_WAIT: begin
        cand_x_d      = pos_x_q;
        cand_y_d      = pos_y_q;
        cand_orient_d = orient_q;
`ifdef HARD_DROP_EN
        if (hd_pend_q) begin
          clr_hd      = 1'b1;
          hd_active_d = 1'b1;
          kind_d      = REQ_GRAV;
          cand_y_d    = pos_y_q + 5'd1;
          state_d     = ST_CHECK_REQ;
        end else
`endif
        if (rot_pend_q) begin
          kind_d        = REQ_ROT;
          cand_orient_d = orient_q + 2'd1;
          state_d       = ST_CHECK_REQ;
        end else if (left_pend_q) begin
          // Column 0 cannot move further left; retire without a check.
          if (pos_x_q == 5'd0) begin
            clr_left = 1'b1;
          end else begin
            kind_d   = REQ_LEFT;
            cand_x_d = pos_x_q - 5'd1;
            state_d  = ST_CHECK_REQ;
          end
        end else if (right_pend_q) begin
          kind_d   = REQ_RIGHT;
          cand_x_d = pos_x_q + 5'd1;
          state_d  = ST_CHECK_REQ;
        end else if (grav_pend_q) begin
          kind_d   = REQ_GRAV;
          cand_y_d = pos_y_q + 5'd1;
          state_d  = ST_CHECK_REQ;
        end
      end
      ST_CHECK_REQ: begin
        state_d = ST_CHECK_RESP;
      end
      ST_CHECK_RESP: begin
        if (!collide) begin
          orient_d = cand_orient_q;
          pos_x_d  = cand_x_q;
          pos_y_d  = cand_y_q;
          state_d  = ST_WAIT;
`ifdef HARD_DROP_EN
          if (hd_active_q) begin
            cand_y_d = cand_y_q + 5'd1;
            state_d  = ST_CHECK_REQ;
          end
`endif
        end else if (kind_q == REQ_SPAWN) begin
          game_over_d = 1'b1;
          state_d     = ST_OVER;
        end else if (kind_q == REQ_GRAV) begin
          state_d = ST_LOCK;
        end else begin
          state_d = ST_WAIT;
        end
        // Retire the flag of the request just resolved.
        if (state_d == ST_WAIT) begin
          case (kind_q)
            REQ_ROT:   clr_rot   = 1'b1;
            REQ_LEFT:  clr_left  = 1'b1;
            REQ_RIGHT: clr_right = 1'b1;
            REQ_GRAV:  clr_grav  = 1'b1;
            default:   ;
          endcase
        end
      end
      ST_LOCK: begin
        clr_all = 1'b1;
        state_d = ST_SPAWN;
`ifdef HARD_DROP_EN
        hd_active_d = 1'b0;
`endif
      end
      ST_OVER: begin
        // Requests seen before the spawn failed are dropped for the next game.
        clr_all = 1'b1;
        if (start) begin
          game_over_d = 1'b0;
          state_d     = ST_SPAWN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // The spawn position is presented as the candidate during SPAWN itself.
    if (state_d == ST_SPAWN) begin
      cand_x_d      = SPAWN_X_C;
      cand_y_d      = 5'd0;
      cand_orient_d = UP;
    end
  end

  // Pending request flags: one deep, a set beats a clear in the same cycle.
  always_comb begin
    rot_pend_d   = (rot_pend_q   & ~(clr_rot   | clr_all)) | (rotate   & req_en);
    left_pend_d  = (left_pend_q  & ~(clr_left  | clr_all)) | (mv_left  & req_en);
    right_pend_d = (right_pend_q & ~(clr_right | clr_all)) | (mv_right & req_en);
    grav_pend_d  = (grav_pend_q  & ~(clr_grav  | clr_all)) | grav_tick;
`ifdef HARD_DROP_EN
    hd_pend_d    = (hd_pend_q    & ~(clr_hd    | clr_all)) | (hard_drop & req_en);
`endif
  end

  // State registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      shape_q       <= LINE;
      kind_q        <= REQ_ROT;
      orient_q      <= UP;
      pos_x_q       <= SPAWN_X_C;
      pos_y_q       <= 5'd0;
      cand_x_q      <= 5'd0;
      cand_y_q      <= 5'd0;
      cand_orient_q <= 2'd0;
      game_over_q   <= 1'b0;
      rot_pend_q    <= 1'b0;
      left_pend_q   <= 1'b0;
      right_pend_q  <= 1'b0;
      grav_pend_q   <= 1'b0;
`ifdef HARD_DROP_EN
      hd_pend_q     <= 1'b0;
      hd_active_q   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      shape_q       <= shape_d;
      kind_q        <= kind_d;
      orient_q      <= orient_d;
      pos_x_q       <= pos_x_d;
      pos_y_q       <= pos_y_d;
      cand_x_q      <= cand_x_d;
      cand_y_q      <= cand_y_d;
      cand_orient_q <= cand_orient_d;
      game_over_q   <= game_over_d;
      rot_pend_q    <= rot_pend_d;
      left_pend_q   <= left_pend_d;
      right_pend_q  <= right_pend_d;
      grav_pend_q   <= grav_pend_d;
`ifdef HARD_DROP_EN
      hd_pend_q     <= hd_pend_d;
      hd_active_q   <= hd_active_d;
`endif
    end
  end

  assign cand_x      = cand_x_q;
  assign cand_y      = cand_y_q;
  assign cand_orient = cand_orient_q;
  assign cand_valid  = (state_q == ST_SPAWN) || (state_q == ST_CHECK_REQ);
  assign shape_req   = shape_q;
  assign orient      = orient_q;
  assign pos_x       = pos_x_q;
  assign pos_y       = pos_y_q;
  assign lock_pulse  = (state_q == ST_LOCK);
  assign game_over   = game_over_q;
  assign dbg_state   = state_q;

endmodule

// File: doc/piece_ctrl.md
Name: piece_ctrl

Overview:
Sequences the active falling tetromino: spawns a piece, applies move/rotate/gravity requests, validates each candidate against an external collision checker, and locks the piece when it can no longer fall. Sits between player input and gravity timing on one side, and the single_shape generator plus board/collision logic on the other. Drives shape_req/orient to the shape generator and the piece position to the renderer.

Parameters:
BOARD_W, 10, board width in cells
BOARD_H, 20, board height in cells
DROP_CYCLES, 50_000_000, clk cycles between gravity steps
SPAWN_X, 3, column of the 4x4 box's left edge at spawn

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  pulse; leave IDLE/OVER and begin a game
next_shape  in  3  shape code 0-6 for the next spawn, sampled in SPAWN
mv_left  in  1  one-cycle request pulse
mv_right  in  1  one-cycle request pulse
rotate  in  1  one-cycle request pulse
cand_x  out  5  candidate box column
cand_y  out  5  candidate box row
cand_orient  out  2  candidate orientation
cand_valid  out  1  candidate presented to the checker this cycle
collide  in  1  checker result for the candidate presented on the previous cycle
shape_req  out  3  active shape, to single_shape
orient  out  2  active orientation, to single_shape: 00 up, 01 right, 10 down, 11 left
pos_x  out  5  active box column
pos_y  out  5  active box row
lock_pulse  out  1  one cycle; the piece is committed to the board at pos_x/pos_y/orient
game_over  out  1  level; spawn collided

Behaviour:
- Reset values: state=IDLE; shape_req=0; orient=00; pos_x=SPAWN_X; pos_y=0; cand_*=0; cand_valid=0; lock_pulse=0; game_over=0; pending flags=0; gravity counter=0.
- States: IDLE, SPAWN, WAIT, CHECK_REQ, CHECK_RESP, LOCK, OVER.
- IDLE: start -> SPAWN.
- SPAWN:
  - Load shape_req=next_shape, orient=00, pos_x=SPAWN_X, pos_y=0.
  - Present this position as the candidate (cand_valid=1) -> CHECK_RESP, tagged as a spawn check.
- WAIT:
  - Select the highest-priority pending request: rotate > left > right > gravity.
  - Form the candidate, then go to CHECK_REQ. With nothing pending, stay in WAIT.
- CHECK_REQ: cand_valid=1 for exactly one cycle -> CHECK_RESP.
- CHECK_RESP: sample collide.
  - collide=0: copy the candidate into the active registers, clear that request's pending flag -> WAIT.
  - collide=1 on a move or rotate: discard the candidate, clear the flag -> WAIT.
  - collide=1 on gravity -> LOCK.
  - collide=1 on a spawn check: game_over=1 -> OVER.
- LOCK: lock_pulse=1 for one cycle; clear all pending flags -> SPAWN.
- OVER: hold all outputs; start -> clear game_over -> SPAWN.
- Candidate forms:
  - rotate: orient+1 mod 4.
  - left: pos_x-1. When pos_x==0 the request is rejected internally in WAIT, no check issued.
  - right: pos_x+1. The right edge and the floor are handled by the checker, which counts off-board cells as collisions.
  - gravity: pos_y+1.
- Pending flags:
  - One per request type. Set by the input pulse in any state except IDLE/OVER.
  - A pulse while already pending is absorbed; requests do not queue deeper than one.
  - A set and a clear of the same flag in one cycle: the set wins.
- Gravity counter:
  - Counts 0..DROP_CYCLES-1 in all states except IDLE/OVER; on wrap it sets the gravity flag.
  - Reset to 0 in SPAWN.
- Latency: request pulse to updated pos/orient = 3 cycles minimum (WAIT, CHECK_REQ, CHECK_RESP). Spawn to first WAIT = 2 cycles.
- reset mid-operation: every register returns to its reset value on the next edge; the in-flight check is discarded.

Optional Feature:
HARD_DROP_EN:
- Defined: adds input hard_drop (pulse) with priority above rotate. While a hard drop is active, gravity candidates are issued back-to-back (CHECK_REQ/CHECK_RESP loop, bypassing WAIT) until collide=1, then LOCK. Other requests are ignored but stay pending until LOCK clears them.
- Undefined: no hard_drop port; no hard-drop logic.

Decomposition:
- Package tetris_pkg:
  - shape_t enum (LINE=0, SQUARE, T, L, J, Z, S).
  - orient_t constants UP=00, RIGHT=01, DOWN=10, LEFT=11.
  - ctrl_state_t enum.
  - BOARD_W/BOARD_H defaults.
- Sub-module gravity_timer: parameter DROP_CYCLES; inputs clk, reset, en, clr; output tick, a one-cycle pulse on counter wrap.

Test Plan:
- reset held 2 cycles, then start with next_shape=3 -> after 2 cycles WAIT with shape_req=3, orient=00, pos_x=3, pos_y=0, game_over=0.
- rotate pulse, collide=0 -> orient=01 three cycles later. Four rotates -> orient=00 (wrap).
- pos_x=0 plus mv_left -> no cand_valid asserted, pos_x stays 0. mv_right with collide=1 -> pos_x unchanged, no lock_pulse.
- DROP_CYCLES=4; hold collide=0 for 3 ticks, then collide=1 -> pos_y=3, lock_pulse exactly 1 cycle, then SPAWN reloads pos_y=0.
- rotate and mv_left pulsed in the same cycle -> rotate checked first, left checked next; both applied when collide=0.
- Spawn check returns collide=1 -> game_over=1, outputs frozen, request pulses ignored. start -> game_over=0 and a new spawn. reset mid-CHECK_RESP -> all reset values.
